// File: rtl/onewire_tx_arbiter.sv
// onewire_tx_arbiter
//   Round-robin arbiter plus frame sequencer for a pulse-width-coded one-wire line.
//   While idle, the first requester at or after the round-robin pointer wins. Its byte
//   is latched and then sent LSB first. Each bit is a low start phase followed by a
//   high phase (for a '1') or a longer low phase (for a '0'). The frame ends with a
//   high stop phase and an idle-high gap.
// Ports
//   clk       clock
//   rst       asynchronous, active-high reset
//   req       per-requester level request, held until ack
//   req_data  requester i byte at [i*DATA_SIZE +: DATA_SIZE]
//   ack       one-hot 1-cycle pulse, that requester's data was latched
//   grant_id  index of the requester currently on the line
//   busy      high from the ack cycle through the last gap cycle
//   sg_out    one-wire line, idle high
//   tx_done   1-cycle pulse on the last stop cycle
module onewire_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned START_PERIOD = 5,
    parameter int unsigned BIT1_PERIOD  = 20,
    parameter int unsigned BIT0_PERIOD  = 10,
    parameter int unsigned STOP_PERIOD  = 15,
    parameter int unsigned GAP_PERIOD   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           sg_out,
    output logic                           tx_done
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned M1   = (START_PERIOD > BIT1_PERIOD) ? START_PERIOD : BIT1_PERIOD;
    localparam int unsigned M2   = (BIT0_PERIOD > STOP_PERIOD) ? BIT0_PERIOD : STOP_PERIOD;
    localparam int unsigned M3   = (M1 > M2) ? M1 : M2;
    localparam int unsigned MaxP = (M3 > GAP_PERIOD) ? M3 : GAP_PERIOD;
    localparam int unsigned CntW = $clog2(MaxP) + 1;
    localparam int unsigned BitW = $clog2(DATA_SIZE + 1);

    typedef enum logic [2:0] {StIdle, StStart, StBit, StStop, StGap} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_SIZE-1:0]   shreg_q, shreg_d;
    logic [IdW-1:0]         rr_q, rr_d;
    logic [IdW-1:0]         gid_q, gid_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   sg_q, sg_d;
    logic                   done_q, done_d;

    logic                   win_valid;
    logic [IdW-1:0]         win_idx;
    logic                   bit_last;

    // Scan requesters starting at the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        logic [IdW:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (IdW+1)'(i);
            if (cand >= (IdW+1)'(NUM_REQ)) begin
                cand = cand - (IdW+1)'(NUM_REQ);
            end
            if (!win_valid && req[cand[IdW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IdW-1:0];
            end
        end
    end

    assign bit_last = shreg_q[0] ? (cnt_q == CntW'(BIT1_PERIOD - 1))
                                 : (cnt_q == CntW'(BIT0_PERIOD - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        ack_d     = '0;
        busy_d    = busy_q;
        sg_d      = sg_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                sg_d  = 1'b1;
                if (win_valid) begin
                    ack_d[win_idx] = 1'b1;
                    gid_d          = win_idx;
                    busy_d         = 1'b1;
                    shreg_d        = req_data[win_idx*DATA_SIZE +: DATA_SIZE];
                    sg_d           = 1'b0;
                    state_d        = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntW'(START_PERIOD - 1)) begin
                    sg_d    = shreg_q[0];
                    cnt_d   = '0;
                    state_d = StBit;
                end
            end
            StBit: begin
                if (bit_last) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = '0;
                    if (bit_cnt_q == BitW'(DATA_SIZE - 1)) begin
                        bit_cnt_d = '0;
                        sg_d      = 1'b1;
                        state_d   = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sg_d      = 1'b0;
                        state_d   = StStart;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CntW'(STOP_PERIOD - 1)) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GAP_PERIOD - 1)) begin
                    rr_d    = (gid_q == IdW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered pulse: high exactly while the stop phase sits in its final cycle.
    assign done_d = (state_d == StStop) && (cnt_d == CntW'(STOP_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rr_q      <= '0;
            gid_q     <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            sg_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rr_q      <= rr_d;
            gid_q     <= gid_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            sg_q      <= sg_d;
            done_q    <= done_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
    assign sg_out   = sg_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_onewire_tx_arbiter.sv
// tb_onewire_tx_arbiter
//   Self-checking bench for onewire_tx_arbiter. A per-cycle reference model turns every
//   grant into the expected line waveform (queue of levels) and compares all outputs.
//   Scenario tasks check ack order, frame lengths and decode bytes back off the line.
module tb_onewire_tx_arbiter;

    localparam int N   = 4;
    localparam int DS  = 8;
    localparam int SP  = 5;
    localparam int B1  = 20;
    localparam int B0  = 10;
    localparam int STP = 15;
    localparam int GP  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DS-1:0]   req_data = '0;
    logic [N-1:0]      ack;
    logic [1:0]        grant_id;
    logic              busy;
    logic              sg_out;
    logic              tx_done;

    onewire_tx_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .sg_out   (sg_out),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit m_sg[$];
    bit m_td[$];
    int m_rr   = 0;
    int m_gid  = 0;
    int m_pend = -1;

    always @(negedge clk) begin : model
        logic [N-1:0]  e_ack;
        logic          e_busy, e_sg, e_td;
        logic [1:0]    e_gid;
        logic [DS-1:0] d;
        int            w;
        if (rst) begin
            e_ack = '0; e_busy = 1'b0; e_sg = 1'b1; e_td = 1'b0; e_gid = '0;
            m_sg.delete(); m_td.delete();
            m_rr = 0; m_gid = 0; m_pend = -1;
        end else begin
            e_ack = '0;
            if (m_pend >= 0) e_ack[m_pend] = 1'b1;
            m_pend = -1;
            e_gid  = 2'(m_gid);
            e_busy = (m_sg.size() != 0);
            if (e_busy) begin
                e_sg = m_sg.pop_front();
                e_td = m_td.pop_front();
                if (m_sg.size() == 0) m_rr = (m_gid + 1) % N;
            end else begin
                e_sg = 1'b1;
                e_td = 1'b0;
            end
        end
        n_checks++;
        if (ack !== e_ack || grant_id !== e_gid || busy !== e_busy ||
            sg_out !== e_sg || tx_done !== e_td) begin
            n_errors++;
            $display("FAIL cycle_model t=%0t got ack=%b gid=%0d busy=%b sg=%b td=%b want ack=%b gid=%0d busy=%b sg=%b td=%b",
                     $time, ack, grant_id, busy, sg_out, tx_done,
                     e_ack, e_gid, e_busy, e_sg, e_td);
        end
        // Idle cycle with pending requests: the next cycle starts a frame.
        if (!rst && !e_busy && req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
            m_pend = w;
            m_gid  = w;
            d = req_data[w*DS +: DS];
            for (int b = 0; b < DS; b++) begin
                repeat (SP) begin m_sg.push_back(1'b0); m_td.push_back(1'b0); end
                if (d[b]) repeat (B1) begin m_sg.push_back(1'b1); m_td.push_back(1'b0); end
                else      repeat (B0) begin m_sg.push_back(1'b0); m_td.push_back(1'b0); end
            end
            for (int k = 0; k < STP; k++) begin
                m_sg.push_back(1'b1); m_td.push_back(k == STP - 1);
            end
            repeat (GP) begin m_sg.push_back(1'b1); m_td.push_back(1'b0); end
        end
    end

    // Bench-side logs filled by step().
    bit            line_log[$];
    int            ack_pos[$];
    int            ack_who[$];
    logic [DS-1:0] ack_dat[$];
    int            td_count = 0;
    int            busy_cnt = 0;
    logic [N-1:0]  keep = '0;

    task automatic clear_logs();
        line_log.delete(); ack_pos.delete(); ack_who.delete(); ack_dat.delete();
        td_count = 0; busy_cnt = 0;
    endtask

    // One clock; requesters react to their ack (drop req unless kept, new data if dropped).
    task automatic step();
        @(posedge clk); #1;
        line_log.push_back(sg_out);
        if (tx_done) td_count++;
        if (busy) busy_cnt++;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                ack_pos.push_back(line_log.size() - 1);
                ack_who.push_back(i);
                ack_dat.push_back(req_data[i*DS +: DS]);
                if (!keep[i]) begin
                    req[i] = 1'b0;
                    req_data[i*DS +: DS] = DS'($urandom);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while ((req != '0 || busy) && k < limit) begin step(); k++; end
        n_checks++;
        if (k >= limit) begin
            n_errors++;
            $display("FAIL drain_timeout got %0d cycles want < %0d", k, limit);
        end
        step();
    endtask

    task automatic run_until_acks(input int n, input int limit);
        int k = 0;
        while (ack_who.size() < n && k < limit) begin step(); k++; end
        n_checks++;
        if (k >= limit) begin
            n_errors++;
            $display("FAIL ack_timeout got %0d acks want %0d", ack_who.size(), n);
        end
    endtask

    function automatic logic [DS-1:0] decode(input int p);
        logic [DS-1:0] v = '0;
        for (int b = 0; b < DS; b++) begin
            if (p + SP < line_log.size()) v[b] = line_log[p + SP];
            p += v[b] ? (SP + B1) : (SP + B0);
        end
        return v;
    endfunction

    function automatic int frame_len(input logic [DS-1:0] d);
        int ones = $countones(d);
        return ones * (SP + B1) + (DS - ones) * (SP + B0) + STP + GP;
    endfunction

    task automatic check_decodes(input string name);
        for (int k = 0; k < ack_pos.size(); k++) begin
            n_checks++;
            if (decode(ack_pos[k]) !== ack_dat[k]) begin
                n_errors++;
                $display("FAIL %s_decode[%0d] got %h want %h", name, k, decode(ack_pos[k]), ack_dat[k]);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({ack, grant_id, busy, sg_out, tx_done} !== {4'b0, 2'b0, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values got ack=%b gid=%0d busy=%b sg=%b td=%b want 0 0 0 1 0",
                     ack, grant_id, busy, sg_out, tx_done);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || sg_out !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_idle got busy=%b sg=%b want 0 1", busy, sg_out);
        end
    endtask

    task automatic test_single();
        clear_logs();
        req_data[0*DS +: DS] = 8'hA5;
        req = 4'b0001;
        step();
        n_checks++;
        if (ack_who.size() != 1 || ack_pos.size() != 1 || ack_pos[0] != 0) begin
            n_errors++;
            $display("FAIL single_ack_latency got %0d acks want ack[0] 1 cycle after req", ack_who.size());
        end
        wait_drain(1000);
        check_decodes("single");
        n_checks++;
        if (td_count != 1 || busy_cnt != frame_len(8'hA5)) begin
            n_errors++;
            $display("FAIL single_frame got td=%0d busy=%0d want td=1 busy=%0d",
                     td_count, busy_cnt, frame_len(8'hA5));
        end
    endtask

    task automatic test_round_robin();
        int exp_who[5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        clear_logs();
        for (int i = 0; i < N; i++) req_data[i*DS +: DS] = DS'(8'h10 + i);
        keep = 4'b1111;
        req  = 4'b1111;
        run_until_acks(5, 2000);
        keep = '0;
        req  = '0;
        wait_drain(1000);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= ack_who.size() || ack_who[k] != exp_who[k] ||
                ack_dat[k] !== DS'(8'h10 + exp_who[k])) begin
                n_errors++;
                $display("FAIL rr_order[%0d] got %0d want %0d", k,
                         (k < ack_who.size()) ? ack_who[k] : -1, exp_who[k]);
            end
        end
        check_decodes("rr");
    endtask

    task automatic test_back_to_back_wrap();
        int exp_who[4] = '{1, 0, 1, 2};
        pulse_reset();
        clear_logs();
        req = 4'b0010;
        run_until_acks(1, 100);
        wait_drain(1000);
        // Pointer now 2; requester 1 keeps requesting after its ack.
        keep = 4'b0010;
        req  = 4'b0011;
        run_until_acks(3, 2000);
        req[2] = 1'b1;
        run_until_acks(4, 1000);
        keep = '0;
        req  = '0;
        wait_drain(1000);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= ack_who.size() || ack_who[k] != exp_who[k]) begin
                n_errors++;
                $display("FAIL wrap_order[%0d] got %0d want %0d", k,
                         (k < ack_who.size()) ? ack_who[k] : -1, exp_who[k]);
            end
        end
        check_decodes("wrap");
    endtask

    task automatic test_lengths();
        logic [DS-1:0] pats[2] = '{8'h00, 8'hFF};
        int            want[2] = '{8*15 + 15 + 4, 8*25 + 15 + 4};
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            req_data[3*DS +: DS] = pats[j];
            req = 4'b1000;
            wait_drain(1000);
            n_checks++;
            if (busy_cnt != want[j] || td_count != 1) begin
                n_errors++;
                $display("FAIL frame_len_%h got busy=%0d td=%0d want busy=%0d td=1",
                         pats[j], busy_cnt, td_count, want[j]);
            end
            check_decodes("len");
        end
    endtask

    task automatic test_reset_midframe();
        logic [DS-1:0] d = DS'($urandom);
        int            offs = 2;
        clear_logs();
        req_data[2*DS +: DS] = d;
        req = 4'b0100;
        run_until_acks(1, 100);
        for (int b = 0; b < 3; b++) offs += d[b] ? (SP + B1) : (SP + B0);
        repeat (offs) step();
        @(posedge clk); #3 rst = 1'b1;
        #1;
        n_checks++;
        if (sg_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || ack !== '0) begin
            n_errors++;
            $display("FAIL midframe_reset got sg=%b busy=%b td=%b ack=%b want 1 0 0 0",
                     sg_out, busy, tx_done, ack);
        end
        @(posedge clk); #1 rst = 1'b0;
        td_count = 0;
        repeat (40) step();
        n_checks++;
        if (td_count != 0 || ack_who.size() != 1) begin
            n_errors++;
            $display("FAIL midframe_lost got td=%0d acks=%0d want 0 1", td_count, ack_who.size());
        end
        clear_logs();
        req = 4'b1001;
        run_until_acks(1, 100);
        n_checks++;
        if (ack_who.size() < 1 || ack_who[0] != 0) begin
            n_errors++;
            $display("FAIL midframe_ptr0 got %0d want 0", (ack_who.size() > 0) ? ack_who[0] : -1);
        end
        wait_drain(2000);
        check_decodes("after_rst");
    endtask

    task automatic test_withdraw();
        clear_logs();
        req = 4'b0001;
        run_until_acks(1, 100);
        repeat (3) step();
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        wait_drain(1000);
        repeat (5) step();
        n_checks++;
        if (ack_who.size() != 1 || ack_who[0] != 0) begin
            n_errors++;
            $display("FAIL withdraw got %0d acks want only ack[0]", ack_who.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            for (int i = 0; i < N; i++) req_data[i*DS +: DS] = DS'($urandom);
            req = N'($urandom_range(1, 15));
            repeat ($urandom_range(5, 200)) step();
            req = req | N'($urandom_range(0, 15));
            wait_drain(4000);
            n_checks++;
            if (td_count != ack_who.size()) begin
                n_errors++;
                $display("FAIL random_done[%0d] got td=%0d want %0d", r, td_count, ack_who.size());
            end
            check_decodes("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_wrap();
        test_lengths();
        test_reset_midframe();
        test_withdraw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
